// File: rtl/hqm_system_rf_fifo_ctl_4x21_pkg.sv
// Shared constants and types for the 4x21 RF-backed FIFO controller.
package hqm_system_rf_fifo_pkg;

    localparam int DEPTH      = 4;
    localparam int DWIDTH     = 21;
    localparam int AW         = $clog2(DEPTH);
    localparam int OBUF_DEPTH = 2;

    // Entry count wide enough for RF + in-flight read + obuf (0..6).
    typedef logic [2:0] cnt_t;

endpackage

// File: rtl/hqm_system_rf_fifo_ctl_4x21_obuf.sv
// Two-entry output prefetch buffer; absorbs RF read data so the FIFO
// can pop every cycle despite the RF's one-cycle read latency.
module hqm_system_rf_fifo_obuf
    import hqm_system_rf_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [DWIDTH-1:0] rd_data,
    output logic [1:0]        cnt
);

    logic [DWIDTH-1:0] buf_q [OBUF_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt_q;
    logic              rd_fire;

    assign rd_fire  = rd_en & rd_valid;
    assign rd_valid = (cnt_q != 2'd0);
    assign rd_data  = buf_q[rd_ptr];
    assign cnt      = cnt_q;

    // Storage, pointers and occupancy; write and read in one cycle both apply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (wr_en) begin
                buf_q[wr_ptr] <= wr_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (rd_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + 2'(wr_en) - 2'(rd_fire);
        end
    end

endmodule

// File: rtl/hqm_system_rf_fifo_ctl_4x21.sv
// Valid/ready FIFO controller driving the 4x21 power-gated RF macro.
// Entries live in the RF; a 2-entry prefetch buffer hides read latency.
module hqm_system_rf_fifo_ctl_4x21
    import hqm_system_rf_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DWIDTH-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DWIDTH-1:0] pop_data,
    output logic              mem_we,
    output logic [AW-1:0]     mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_re,
    output logic [AW-1:0]     mem_raddr,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_pwr_ok,
    output logic [2:0]        fifo_cnt,
    output logic              idle,
    output logic              err_pwr_loss
);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    cnt_t          rf_cnt;
    logic          rd_inflight;
    logic          run;
    logic          err_q;
    logic [1:0]    obuf_cnt;
    cnt_t          obuf_occ;
    logic          push_fire;
    logic          pop_fire;
    logic          read_issue;
    logic          pwr_drop;

    // push_ready uses only registered state (run, rf_cnt) plus the
    // already-synchronous power flag; run keeps it low right after reset.
    assign push_ready = run & mem_pwr_ok & (rf_cnt < cnt_t'(DEPTH));
    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = pop_valid & pop_ready;

    // Slots already spoken for in the obuf; a pop this cycle frees one.
    assign obuf_occ   = cnt_t'(obuf_cnt) + cnt_t'(rd_inflight);
    assign read_issue = mem_pwr_ok & (rf_cnt != '0) &
                        (obuf_occ < (cnt_t'(2) + cnt_t'(pop_fire)));

    // Losing power with live RF data drops those entries.
    assign pwr_drop = ~mem_pwr_ok & (rf_cnt != '0);

    assign mem_we    = push_fire;
    assign mem_waddr = wptr;
    assign mem_wdata = push_data;
    assign mem_re    = read_issue;
    assign mem_raddr = rptr;

    assign fifo_cnt     = rf_cnt + cnt_t'(rd_inflight) + cnt_t'(obuf_cnt);
    assign idle         = (rf_cnt == '0) & ~rd_inflight;
    assign err_pwr_loss = err_q;

    // RF pointers, occupancy, read-in-flight flag and sticky power error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            rf_cnt      <= '0;
            rd_inflight <= 1'b0;
            run         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            run         <= 1'b1;
            rd_inflight <= read_issue;
            if (pwr_drop) begin
                wptr   <= '0;
                rptr   <= '0;
                rf_cnt <= '0;
                err_q  <= 1'b1;
            end else begin
                if (push_fire) begin
                    wptr <= wptr + AW'(1);
                end
                if (read_issue) begin
                    rptr <= rptr + AW'(1);
                end
                rf_cnt <= rf_cnt + cnt_t'(push_fire) - cnt_t'(read_issue);
            end
        end
    end

    hqm_system_rf_fifo_obuf u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (rd_inflight),
        .wr_data  (mem_rdata),
        .rd_en    (pop_ready),
        .rd_valid (pop_valid),
        .rd_data  (pop_data),
        .cnt      (obuf_cnt)
    );

endmodule
